id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of PC and data fields.
REQ-002 SHALL have ports: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: stall  input  1  hold all outputs this cycle.
REQ-005 SHALL have ports: flush  input  1  insert bubble (taken-branch squash).
REQ-006 SHALL have ports: id_valid  input  1  ID slot holds a real instruction.
REQ-007 SHALL have ports: ALUOp  input  2  from Control.
REQ-008 SHALL have ports: ALUSrc, RegDst, Branch, MemRead, MemWrite, RegWrite, MemtoReg  input  1 each  from Control.
REQ-009 SHALL have ports: id_pc4, id_rdata1, id_rdata2, id_imm  input  DATA_W each  PC+4, register reads, sign-extended immediate.
REQ-010 SHALL have ports: id_rs, id_rt, id_rd  input  5 each  register specifiers.
REQ-011 SHALL have ports: ex_ALUOp  output  2; ex_ALUSrc, ex_RegDst, ex_Branch, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg  output  1 each  registered control.
REQ-012 SHALL have ports: ex_pc4, ex_rdata1, ex_rdata2, ex_imm  output  DATA_W each; ex_rs, ex_rt, ex_rd  output  5 each  registered data.
REQ-013 SHALL have ports: ex_valid  output  1  EX slot holds a real instruction.
REQ-014 SHALL have ports: bubble_cnt  output  16  bubbles inserted (present only with macro, see Configuration).

Function
REQ-015 SHALL register all outputs; input-to-output latency exactly one clk edge; no combinational input-to-output path.
REQ-016 SHALL apply per-edge priority: flush > stall > load.
REQ-017 Load (flush=0, stall=0): every ex_* SHALL take its id_* / Control input; ex_valid SHALL take id_valid.
REQ-018 Stall (flush=0, stall=1): every output SHALL hold its current value, including ex_valid.
REQ-019 Flush (flush=1, any stall): all ex_ control outputs and ex_valid SHALL become 0; data/specifier outputs SHALL hold.
REQ-020 Bubble SHALL be defined as an edge where flush=1, or a load with id_valid=0.
REQ-021 When ex_valid=0, all ex_ control outputs SHALL be 0 (no write or memory side effect reaches later stages).
REQ-022 Control inputs already zeroed upstream by hazard detection SHALL pass through unchanged under load; no re-decode.

Reset
REQ-023 rst_n low SHALL immediately, independent of clk, clear every output (controls, data, specifiers, ex_valid, bubble_cnt) to 0.
REQ-024 Reset asserted mid-stall or mid-flush SHALL override both; first edge after rst_n rises SHALL follow REQ-016.

Configuration
REQ-025 Macro ID_EX_BUBBLE_CNT_EN defined: bubble_cnt port and 16-bit counter SHALL exist, increment by 1 per bubble edge (REQ-020), saturate at 0xFFFF, not count stall edges.
REQ-026 Macro undefined: bubble_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-027 Reset: drive rst_n=0 mid-cycle with nonzero outputs -> all outputs 0 before next edge.
REQ-028 Load LW: opcode-derived controls ALUSrc=1, MemRead=1, RegWrite=1, MemtoReg=1, id_imm=0x00000010, id_valid=1 -> next edge same values on ex_*, ex_valid=1.
REQ-029 Stall: load R-type (ALUOp=2'b10, RegDst=1, RegWrite=1), then stall=1 for 3 edges with changed inputs -> outputs unchanged all 3 edges.
REQ-030 Flush+stall same edge with ex_RegWrite=1, ex_rd=5'd8 -> ex_RegWrite=0, ex_valid=0, ex_rd still 8.
REQ-031 Counter (macro on): 2 flushes + 1 load with id_valid=0 + 4 stalls -> bubble_cnt=3; preload to 0xFFFF, one more flush -> stays 0xFFFF.
REQ-032 Macro off: elaborate and rerun REQ-027..030 -> identical results, no bubble_cnt port.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with stall hold and flush bubble.
// Optional feature: define ID_EX_BUBBLE_CNT_EN to add a saturating 16-bit
// bubble counter on port bubble_cnt.
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [1:0]        ALUOp,
  input  logic              ALUSrc,
  input  logic              RegDst,
  input  logic              Branch,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  output logic [1:0]        ex_ALUOp,
  output logic              ex_ALUSrc,
  output logic              ex_RegDst,
  output logic              ex_Branch,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_RegWrite,
  output logic              ex_MemtoReg,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              ex_valid
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0]       bubble_cnt
`endif
);

  logic load;
  assign load = !flush && !stall;

  // Control and valid: flush clears, stall holds, load copies. An invalid
  // slot loads zeroed controls so nothing with side effects reaches EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ALUOp    <= 2'b00;
      ex_ALUSrc   <= 1'b0;
      ex_RegDst   <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_valid    <= 1'b0;
    end else if (flush) begin
      ex_ALUOp    <= 2'b00;
      ex_ALUSrc   <= 1'b0;
      ex_RegDst   <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_valid    <= 1'b0;
    end else if (!stall) begin
      ex_ALUOp    <= id_valid ? ALUOp : 2'b00;
      ex_ALUSrc   <= id_valid & ALUSrc;
      ex_RegDst   <= id_valid & RegDst;
      ex_Branch   <= id_valid & Branch;
      ex_MemRead  <= id_valid & MemRead;
      ex_MemWrite <= id_valid & MemWrite;
      ex_RegWrite <= id_valid & RegWrite;
      ex_MemtoReg <= id_valid & MemtoReg;
      ex_valid    <= id_valid;
    end
  end

  // Data and specifiers only change on a load; flush leaves them in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc4    <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_rs     <= 5'd0;
      ex_rt     <= 5'd0;
      ex_rd     <= 5'd0;
    end else if (load) begin
      ex_pc4    <= id_pc4;
      ex_rdata1 <= id_rdata1;
      ex_rdata2 <= id_rdata2;
      ex_imm    <= id_imm;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_rd     <= id_rd;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic bubble;
  assign bubble = flush || (load && !id_valid);

  // Count bubble edges, saturating at all-ones; stall edges are not bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= 16'h0000;
    end else if (bubble && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; inputs change on the falling edge,
// outputs are checked 1 ns after the rising edge.
module tb_id_ex_stage;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n, stall, flush, id_valid;
  logic [1:0]        ALUOp;
  logic              ALUSrc, RegDst, Branch, MemRead, MemWrite, RegWrite, MemtoReg;
  logic [DATA_W-1:0] id_pc4, id_rdata1, id_rdata2, id_imm;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic [1:0]        ex_ALUOp;
  logic              ex_ALUSrc, ex_RegDst, ex_Branch, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg;
  logic [DATA_W-1:0] ex_pc4, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]        ex_rs, ex_rt, ex_rd;
  logic              ex_valid;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0]       bubble_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .ALUOp(ALUOp), .ALUSrc(ALUSrc), .RegDst(RegDst), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .id_pc4(id_pc4), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc), .ex_RegDst(ex_RegDst), .ex_Branch(ex_Branch),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_RegWrite(ex_RegWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_pc4(ex_pc4), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_valid(ex_valid)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed control vector: {ALUOp, ALUSrc, RegDst, Branch, MemRead, MemWrite, RegWrite, MemtoReg}
  function automatic logic [8:0] ctl();
    return {ex_ALUOp, ex_ALUSrc, ex_RegDst, ex_Branch, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg};
  endfunction

  task automatic set_ctl(input logic [8:0] c);
    {ALUOp, ALUSrc, RegDst, Branch, MemRead, MemWrite, RegWrite, MemtoReg} = c;
  endtask

  task automatic set_data(input logic [31:0] pc4, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd);
    id_pc4 = pc4; id_rdata1 = r1; id_rdata2 = r2; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'(ctl()), 64'd0);
    chk({tag, "_valid"}, 64'(ex_valid), 64'd0);
    chk({tag, "_data"}, 64'(ex_pc4 | ex_rdata1 | ex_rdata2 | ex_imm), 64'd0);
    chk({tag, "_spec"}, 64'({ex_rs, ex_rt, ex_rd}), 64'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
    chk({tag, "_cnt"}, 64'(bubble_cnt), 64'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    set_ctl(9'd0);
    set_data(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #2;
    chk_all_zero("reset_init");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // LW: ALUSrc, MemRead, RegWrite, MemtoReg
    @(negedge clk);
    id_valid = 1'b1;
    set_ctl(9'b00_1_0_0_1_0_1_1);
    set_data(32'h0000_0104, 32'h0000_1000, 32'h0000_0055, 32'h0000_0010, 5'd4, 5'd5, 5'd0);
    edge_step();
    chk("lw_ctl", 64'(ctl()), 64'(9'b00_1_0_0_1_0_1_1));
    chk("lw_valid", 64'(ex_valid), 64'd1);
    chk("lw_imm", 64'(ex_imm), 64'h10);
    chk("lw_data", 64'({ex_pc4, ex_rdata1}), {32'h0000_0104, 32'h0000_1000});
    chk("lw_spec", 64'({ex_rs, ex_rt, ex_rd}), 64'({5'd4, 5'd5, 5'd0}));

    // Inputs changed mid-cycle must not reach outputs before the edge
    #2;
    set_ctl(9'b11_0_1_1_0_1_0_0);
    set_data(32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3, 5'd9, 5'd10, 5'd11);
    #1;
    chk("no_comb_ctl", 64'(ctl()), 64'(9'b00_1_0_0_1_0_1_1));
    chk("no_comb_pc4", 64'(ex_pc4), 64'h104);

    // Asynchronous reset mid-cycle with nonzero outputs
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // R-type load, then three stall edges with different inputs
    @(negedge clk);
    id_valid = 1'b1;
    set_ctl(9'b10_0_1_0_0_0_1_0);
    set_data(32'h0000_0200, 32'h1111_1111, 32'h2222_2222, 32'h0, 5'd1, 5'd2, 5'd3);
    edge_step();
    chk("rtype_ctl", 64'(ctl()), 64'(9'b10_0_1_0_0_0_1_0));
    chk("rtype_data", {ex_rdata1, ex_rdata2}, {32'h1111_1111, 32'h2222_2222});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1'b1;
      id_valid = (i != 1);
      set_ctl(9'b01_1_0_1_1_1_0_1);
      set_data(32'h300 + i, 32'hAAAA_0000 + i, 32'hBBBB_0000, 32'hFFFF_FFF0, 5'd7, 5'd8, 5'd9);
      edge_step();
      chk($sformatf("stall%0d_ctl", i), 64'(ctl()), 64'(9'b10_0_1_0_0_0_1_0));
      chk($sformatf("stall%0d_valid", i), 64'(ex_valid), 64'd1);
      chk($sformatf("stall%0d_data", i), {ex_pc4, ex_rdata1}, {32'h0000_0200, 32'h1111_1111});
      chk($sformatf("stall%0d_spec", i), 64'({ex_rs, ex_rt, ex_rd}), 64'({5'd1, 5'd2, 5'd3}));
    end

    // Load RegWrite to rd=8, then flush and stall on the same edge
    @(negedge clk);
    stall = 1'b0; id_valid = 1'b1;
    set_ctl(9'b10_0_1_0_0_0_1_0);
    set_data(32'h0000_0400, 32'h0000_AAAA, 32'h0000_BBBB, 32'h0, 5'd6, 5'd7, 5'd8);
    edge_step();
    chk("pre_flush_rw", 64'(ex_RegWrite), 64'd1);
    @(negedge clk);
    stall = 1'b1; flush = 1'b1;
    set_data(32'h0000_0500, 32'h0000_CCCC, 32'h0000_DDDD, 32'h5, 5'd1, 5'd2, 5'd9);
    edge_step();
    chk("flush_rw", 64'(ex_RegWrite), 64'd0);
    chk("flush_ctl", 64'(ctl()), 64'd0);
    chk("flush_valid", 64'(ex_valid), 64'd0);
    chk("flush_rd", 64'(ex_rd), 64'd8);
    chk("flush_data", {ex_pc4, ex_rdata1}, {32'h0000_0400, 32'h0000_AAAA});

    // Flush alone (no stall) also squashes controls but keeps data
    @(negedge clk);
    stall = 1'b0; flush = 1'b1;
    edge_step();
    chk("flush_only_valid", 64'(ex_valid), 64'd0);
    chk("flush_only_rd", 64'(ex_rd), 64'd8);

    // Load of an invalid slot: data loads, controls forced to 0
    @(negedge clk);
    flush = 1'b0; id_valid = 1'b0;
    set_ctl(9'b11_1_1_1_1_1_1_1);
    set_data(32'h0000_0600, 32'h0000_0001, 32'h0000_0002, 32'h3, 5'd10, 5'd11, 5'd12);
    edge_step();
    chk("inv_load_ctl", 64'(ctl()), 64'd0);
    chk("inv_load_valid", 64'(ex_valid), 64'd0);
    chk("inv_load_rd", 64'(ex_rd), 64'd12);

    // Reset while stall and flush are both high, then a plain load
    @(negedge clk);
    id_valid = 1'b1;
    set_ctl(9'b01_0_0_1_0_0_0_0);
    edge_step();
    chk("br_load_ctl", 64'(ctl()), 64'(9'b01_0_0_1_0_0_0_0));
    #2;
    stall = 1'b1; flush = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_over_flush");
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    set_ctl(9'b00_1_0_0_0_1_0_0);
    set_data(32'h0000_0700, 32'h0000_0011, 32'h0000_0022, 32'h8, 5'd13, 5'd14, 5'd15);
    edge_step();
    chk("post_rst_ctl", 64'(ctl()), 64'(9'b00_1_0_0_0_1_0_0));
    chk("post_rst_valid", 64'(ex_valid), 64'd1);
    chk("post_rst_imm", 64'(ex_imm), 64'h8);

`ifdef ID_EX_BUBBLE_CNT_EN
    // Counter: 2 flushes, 1 invalid load, 4 stalls (not counted), 1 valid load
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("cnt_rst", 64'(bubble_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    flush = 1'b1;
    edge_step();
    @(negedge clk);
    edge_step();
    @(negedge clk);
    flush = 1'b0; id_valid = 1'b0;
    edge_step();
    chk("cnt_after_3", 64'(bubble_cnt), 64'd3);
    @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) edge_step();
    @(negedge clk);
    stall = 1'b0; id_valid = 1'b1;
    edge_step();
    chk("cnt_stalls", 64'(bubble_cnt), 64'd3);
    @(negedge clk);
    flush = 1'b1;
    for (int i = 0; i < 65532; i++) @(posedge clk);
    #1;
    chk("cnt_full", 64'(bubble_cnt), 64'hFFFF);
    edge_step();
    chk("cnt_sat", 64'(bubble_cnt), 64'hFFFF);
    @(negedge clk);
    flush = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
